// File: rtl/colon_blinker.sv
// ============================================================================
//  Module   : colon_blinker
//  Purpose  : Frame-synchronous blinking colon for the 96x64 OLED clock face.
//             Optional fade-through-dim phase enabled by COLON_FADE_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module colon_blinker #(
    parameter int          X           = 0,
    parameter int          Y           = 0,
    parameter int          X_W         = 7,
    parameter int          Y_W         = 6,
    parameter int          SCALE       = 1,
    parameter logic [15:0] FG          = 16'hFFFF,
    parameter logic [15:0] BG          = 16'h0000,
    parameter int          HALF_PERIOD = 30,
    parameter int          DIM_FRAMES  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_valid,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           frame_start,
    input  logic           blink_en,
    input  logic           sec_tick,
    output logic           out_valid,
    output logic           hit,
    output logic [15:0]    colour
);

    localparam int c_gw      = ((X_W > Y_W) ? X_W : Y_W) + 4;
    localparam int c_cnt_max = (HALF_PERIOD > DIM_FRAMES) ? HALF_PERIOD : DIM_FRAMES;
    localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

    localparam logic [c_gw-1:0] c_x_lo  = c_gw'(X + 5 * SCALE);
    localparam logic [c_gw-1:0] c_x_hi  = c_gw'(X + 7 * SCALE - 1);
    localparam logic [c_gw-1:0] c_yu_lo = c_gw'(Y + 4 * SCALE);
    localparam logic [c_gw-1:0] c_yu_hi = c_gw'(Y + 6 * SCALE - 1);
    localparam logic [c_gw-1:0] c_yl_lo = c_gw'(Y + 7 * SCALE);
    localparam logic [c_gw-1:0] c_yl_hi = c_gw'(Y + 9 * SCALE - 1);

    localparam logic [c_cnt_w-1:0] c_hp_last = c_cnt_w'(HALF_PERIOD - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

`ifdef COLON_FADE_EN
    localparam logic [c_cnt_w-1:0] c_dim_last = c_cnt_w'(DIM_FRAMES - 1);
    // Each RGB565 channel halved independently so no bit bleeds across fields.
    localparam logic [15:0] c_dim = {1'b0, FG[15:12], 1'b0, FG[10:6], 1'b0, FG[4:1]};

    typedef enum logic [1:0] {
        ST_SOLID = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2,
        ST_DIM   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_SOLID = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2
    } state_t;
`endif

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_sync_pend, w_sync_nxt;
    logic                 w_sync;

    logic [c_gw-1:0]      w_xe, w_ye;
    logic                 w_in_x, w_in_up, w_in_lo, w_hit;
    logic [15:0]          w_colour;

    // Zero-extended compare so cells near the screen edge never alias via wrap.
    assign w_xe    = {{(c_gw - X_W){1'b0}}, x};
    assign w_ye    = {{(c_gw - Y_W){1'b0}}, y};
    assign w_in_x  = (w_xe >= c_x_lo)  && (w_xe <= c_x_hi);
    assign w_in_up = (w_ye >= c_yu_lo) && (w_ye <= c_yu_hi);
    assign w_in_lo = (w_ye >= c_yl_lo) && (w_ye <= c_yl_hi);
    assign w_hit   = pix_valid && w_in_x && (w_in_up || w_in_lo);

    assign w_sync  = r_sync_pend | sec_tick;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sync_nxt  = w_sync;
        if (frame_start) begin
            w_sync_nxt = 1'b0;
            if (!blink_en) begin
                w_state_nxt = ST_SOLID;
                w_cnt_nxt   = '0;
            end else if (w_sync) begin
                w_state_nxt = ST_ON;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    ST_SOLID: begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = '0;
                    end
                    ST_ON: begin
                        if (r_cnt == c_hp_last) begin
`ifdef COLON_FADE_EN
                            w_state_nxt = ST_DIM;
`else
                            w_state_nxt = ST_OFF;
`endif
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_one;
                        end
                    end
`ifdef COLON_FADE_EN
                    ST_DIM: begin
                        if (r_cnt == c_dim_last) begin
                            w_state_nxt = ST_OFF;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_one;
                        end
                    end
`endif
                    ST_OFF: begin
                        if (r_cnt == c_hp_last) begin
                            w_state_nxt = ST_ON;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_one;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_SOLID;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_colour = BG;
        if (w_hit) begin
            case (r_state)
                ST_SOLID, ST_ON: w_colour = FG;
`ifdef COLON_FADE_EN
                ST_DIM:          w_colour = c_dim;
`endif
                default:         w_colour = BG;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SOLID;
            r_cnt       <= '0;
            r_sync_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sync_pend <= w_sync_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            hit       <= 1'b0;
            colour    <= BG;
        end else begin
            out_valid <= pix_valid;
            hit       <= w_hit;
            colour    <= w_colour;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_colon_blinker.sv
// ============================================================================
//  Module   : tb_colon_blinker
//  Purpose  : Directed self-checking bench for colon_blinker (both builds).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_colon_blinker;

    logic        clk;
    logic        rst_n;
    logic        pix_valid;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        frame_start;
    logic        blink_en;
    logic        sec_tick;
    logic        out_valid, hit;
    logic [15:0] colour;
    logic        out_valid2, hit2;
    logic [15:0] colour2;

    int n_checks;
    int n_fail;

`ifdef COLON_FADE_EN
    localparam int          c_nfr      = 10;
    localparam int          c_to_off   = 4;  // pulses from ON cnt1 to OFF cnt0
    localparam int          c_solid2off = 6;
    localparam logic [15:0] c_after_on = 16'h7BEF;
`else
    localparam int          c_nfr      = 8;
    localparam int          c_to_off   = 2;
    localparam int          c_solid2off = 4;
    localparam logic [15:0] c_after_on = 16'h0000;
`endif

    logic [15:0] exp_tab [0:9];

    colon_blinker #(
        .X(0), .Y(0), .X_W(7), .Y_W(6), .SCALE(1),
        .FG(16'hFFFF), .BG(16'h0000), .HALF_PERIOD(3), .DIM_FRAMES(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x(x), .y(y),
        .frame_start(frame_start), .blink_en(blink_en), .sec_tick(sec_tick),
        .out_valid(out_valid), .hit(hit), .colour(colour)
    );

    colon_blinker #(
        .X(40), .Y(20), .X_W(7), .Y_W(6), .SCALE(2),
        .FG(16'hFFFF), .BG(16'h0000), .HALF_PERIOD(3), .DIM_FRAMES(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x(x), .y(y),
        .frame_start(frame_start), .blink_en(blink_en), .sec_tick(sec_tick),
        .out_valid(out_valid2), .hit(hit2), .colour(colour2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, input logic fs, input logic st);
        pix_valid   = 1'b1;
        x           = 7'(px);
        y           = 6'(py);
        frame_start = fs;
        sec_tick    = st;
        cyc();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        sec_tick    = 1'b0;
    endtask

    task automatic frame(input logic st);
        frame_start = 1'b1;
        sec_tick    = st;
        cyc();
        frame_start = 1'b0;
        sec_tick    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; pix_valid = 1'b0; x = '0; y = '0;
        frame_start = 1'b0; blink_en = 1'b0; sec_tick = 1'b0;

`ifdef COLON_FADE_EN
        exp_tab = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7BEF,
                    16'h7BEF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
`else
        exp_tab = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000,
                    16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
`endif

        cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_hit",       32'(hit),       32'd0);
        check("rst_colour",    32'(colour),    32'h0000);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Geometry, SCALE=1 at origin
        pix(5, 4, 1'b0, 1'b0);
        check("g1_hit_5_4", 32'(hit), 32'd1);
        check("g1_col_5_4", 32'(colour), 32'hFFFF);
        check("g1_valid",   32'(out_valid), 32'd1);
        pix(6, 8, 1'b0, 1'b0);
        check("g1_hit_6_8", 32'(hit), 32'd1);
        check("g1_col_6_8", 32'(colour), 32'hFFFF);
        pix(4, 4, 1'b0, 1'b0);
        check("g1_hit_4_4", 32'(hit), 32'd0);
        check("g1_col_4_4", 32'(colour), 32'h0000);
        pix(5, 6, 1'b0, 1'b0);
        check("g1_hit_5_6", 32'(hit), 32'd0);
        check("g1_col_5_6", 32'(colour), 32'h0000);
        x = 7'd5; y = 6'd4;
        cyc();
        check("nv_valid",  32'(out_valid), 32'd0);
        check("nv_hit",    32'(hit),       32'd0);
        check("nv_colour", 32'(colour),    32'h0000);

        // Geometry, SCALE=2 at (40,20)
        pix(50, 28, 1'b0, 1'b0);
        check("g2_hit_50_28", 32'(hit2), 32'd1);
        check("g2_col_50_28", 32'(colour2), 32'hFFFF);
        pix(53, 31, 1'b0, 1'b0);
        check("g2_hit_53_31", 32'(hit2), 32'd1);
        pix(54, 28, 1'b0, 1'b0);
        check("g2_hit_54_28", 32'(hit2), 32'd0);
        pix(50, 32, 1'b0, 1'b0);
        check("g2_hit_50_32", 32'(hit2), 32'd0);
        pix(52, 36, 1'b0, 1'b0);
        check("g2_hit_52_36", 32'(hit2), 32'd1);

        // Blink sequence; the pixel sharing a cycle with frame_start sees the old state
        blink_en = 1'b1;
        for (int i = 0; i < c_nfr; i++) begin
            pix(5, 4, 1'b0, 1'b0);
            check($sformatf("blink_f%0d", i), 32'(colour), 32'(exp_tab[i]));
            pix(6, 5, 1'b1, 1'b0);
            check($sformatf("blink_fs%0d", i), 32'(colour), 32'(exp_tab[i]));
        end

        // Now ON cnt1: walk to OFF cnt1, then resync with coincident sec_tick
        for (int i = 0; i <= c_to_off; i++) frame(1'b0);
        pix(5, 4, 1'b0, 1'b0);
        check("off_cnt1", 32'(colour), 32'h0000);
        frame(1'b1);
        pix(5, 4, 1'b0, 1'b0);
        check("sync_coinc", 32'(colour), 32'hFFFF);

        // sec_tick alone is held pending until the next frame_start
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        pix(5, 4, 1'b0, 1'b0);
        check("sync_pend_on2", 32'(colour), 32'hFFFF);
        frame(1'b0);
        pix(5, 4, 1'b0, 1'b0);
        check("after_on", 32'(colour), 32'(c_after_on));

        // blink_en change mid-frame waits for frame_start
        blink_en = 1'b0;
        pix(5, 4, 1'b0, 1'b0);
        check("en_midframe", 32'(colour), 32'(c_after_on));
        frame(1'b0);
        pix(5, 4, 1'b0, 1'b0);
        check("solid_en0", 32'(colour), 32'hFFFF);
        sec_tick = 1'b1;
        cyc();
        sec_tick = 1'b0;
        frame(1'b0);
        pix(6, 7, 1'b0, 1'b0);
        check("tick_dropped", 32'(colour), 32'hFFFF);

        // Reset mid-frame while in BLINK_OFF
        blink_en = 1'b1;
        for (int i = 0; i < c_solid2off; i++) frame(1'b0);
        pix_valid = 1'b1; x = 7'd5; y = 6'd4;
        cyc();
        check("pre_rst_hit", 32'(hit), 32'd1);
        check("pre_rst_col", 32'(colour), 32'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(out_valid), 32'd0);
        check("arst_hit",    32'(hit),       32'd0);
        check("arst_colour", 32'(colour),    32'h0000);
        pix_valid = 1'b0;
        blink_en  = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_col", 32'(colour), 32'h0000);
        pix(5, 4, 1'b0, 1'b0);
        check("post_rst_dot", 32'(colour), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
